// File: rtl/quadrature_decoder_if.sv
// Quadrature decoder pin/result bundle.
// Optional index input Z exists only when QUAD_INDEX_EN is defined.
interface quadrature_decoder_if #(
    parameter int CNT_W = 4
);
    logic             A;
    logic             B;
    logic             ErrClr;
`ifdef QUAD_INDEX_EN
    logic             Z;
`endif
    logic             Step;
    logic             UD;
    logic [CNT_W-1:0] Position;
    logic             Err;

`ifdef QUAD_INDEX_EN
    modport master (output A, B, ErrClr, Z, input Step, UD, Position, Err);
    modport slave  (input A, B, ErrClr, Z, output Step, UD, Position, Err);
`else
    modport master (output A, B, ErrClr, input Step, UD, Position, Err);
    modport slave  (input A, B, ErrClr, output Step, UD, Position, Err);
`endif
endinterface

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: synchronizes and glitch-filters encoder phases A/B,
// emits a one-cycle Step with UD direction, keeps a wrapping Position and a
// sticky Err flag for double-phase jumps.
// Define QUAD_INDEX_EN to add index input Z, whose filtered rising edge
// zeroes Position.
module quadrature_decoder #(
    parameter int FILTER_LEN = 3,
    parameter int CNT_W      = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    quadrature_decoder_if.slave   bus
);
`ifdef QUAD_INDEX_EN
    localparam int NPH = 3;       // A, B, Z
`else
    localparam int NPH = 2;       // A, B
`endif
    localparam int INIT_CYC = FILTER_LEN + 2;

    typedef enum logic {INIT, RUN} state_t;

    state_t           state_q, state_d;
    logic [4:0]       init_cnt_q, init_cnt_d;

    logic [NPH-1:0]   pin;
    logic [NPH-1:0]   meta_q, sync_q;
    logic [NPH-1:0]   filt;
    logic [NPH-1:0]   prev_q;

    logic             step_q, step_d;
    logic             ud_q, ud_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             err_q, err_d;

`ifdef QUAD_INDEX_EN
    assign pin = {bus.Z, bus.B, bus.A};
`else
    assign pin = {bus.B, bus.A};
`endif

    // Two-flop synchronizer on every asynchronous phase input
    always_ff @(posedge CLK) begin
        if (Reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= pin;
            sync_q <= meta_q;
        end
    end

    // Per-phase glitch filter: accept a new level after FILTER_LEN differing samples
    for (genvar i = 0; i < NPH; i++) begin : g_filt
        logic       f_q, f_d;
        logic [3:0] c_q, c_d;

        // Next filtered level and run-length count; INIT tracks the pin directly
        always_comb begin
            f_d = f_q;
            c_d = c_q;
            if (state_q == INIT) begin
                f_d = sync_q[i];
                c_d = '0;
            end else if (sync_q[i] == f_q) begin
                c_d = '0;
            end else if (c_q == 4'(FILTER_LEN - 1)) begin
                f_d = sync_q[i];
                c_d = '0;
            end else begin
                c_d = c_q + 4'd1;
            end
        end

        // Filter state register
        always_ff @(posedge CLK) begin
            if (Reset) begin
                f_q <= 1'b0;
                c_q <= '0;
            end else begin
                f_q <= f_d;
                c_q <= c_d;
            end
        end

        assign filt[i] = f_q;
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // FSM next state: hold INIT long enough for the filters to settle on real pin levels
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == INIT) begin
            if (init_cnt_q == 5'(INIT_CYC - 1)) begin
                state_d    = RUN;
                init_cnt_d = '0;
            end else begin
                init_cnt_d = init_cnt_q + 5'd1;
            end
        end
    end

    // Decode: map AB to Gray position 00,01,11,10 -> 0..3; the mod-4 difference
    // gives 1 = up, 3 = down, 2 = illegal double jump, 0 = no change
    logic [1:0] cur_idx, prev_idx, delta;
    logic       run, idx_load;

    assign cur_idx  = {filt[0], filt[0] ^ filt[1]};
    assign prev_idx = {prev_q[0], prev_q[0] ^ prev_q[1]};
    assign delta    = cur_idx - prev_idx;
    assign run      = (state_q == RUN);
`ifdef QUAD_INDEX_EN
    assign idx_load = run && filt[2] && !prev_q[2];
`else
    assign idx_load = 1'b0;
`endif

    // Step/UD/Position/Err next values; index load beats a same-cycle step, Err set beats clear
    always_comb begin
        step_d = run && delta[0];
        ud_d   = ud_q;
        pos_d  = pos_q;
        err_d  = err_q;
        if (step_d) begin
            ud_d  = (delta == 2'd1);
            pos_d = (delta == 2'd1) ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
        end
        if (idx_load) pos_d = '0;
        if (bus.ErrClr) err_d = 1'b0;
        if (run && delta == 2'd2) err_d = 1'b1;
    end

    // Output and previous-phase registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            step_q <= 1'b0;
            ud_q   <= 1'b1;
            pos_q  <= '0;
            err_q  <= 1'b0;
            prev_q <= '0;
        end else begin
            step_q <= step_d;
            ud_q   <= ud_d;
            pos_q  <= pos_d;
            err_q  <= err_d;
            prev_q <= filt;
        end
    end

    assign bus.Step     = step_q;
    assign bus.UD       = ud_q;
    assign bus.Position = pos_q;
    assign bus.Err      = err_q;
endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder (FILTER_LEN=3, CNT_W=4).
// Index checks are compiled in when QUAD_INDEX_EN is defined.
module tb_quadrature_decoder;
    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_cnt = 0;
    int   up_cnt   = 0;
    int   s0, u0;

    quadrature_decoder_if #(.CNT_W(4)) dif ();

    quadrature_decoder #(.FILTER_LEN(3), .CNT_W(4)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count Step pulses away from the active edge
    always @(negedge clk) begin
        if (dif.Step === 1'b1) begin
            step_cnt++;
            if (dif.UD === 1'b1) up_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset for two edges, check reset values, then wait out INIT
    task automatic do_reset(input logic a, input logic b, input string tag);
        dif.A = a; dif.B = b;
        rst = 1'b1;
        cyc(2);
        chk({tag, ".step"}, dif.Step, 0);
        chk({tag, ".ud"},   dif.UD, 1);
        chk({tag, ".pos"},  dif.Position, 0);
        chk({tag, ".err"},  dif.Err, 0);
        rst = 1'b0;
        cyc(10);
    endtask

    // Drive a new AB level right after edge n-1; Step must appear after edge n+5 only
    task automatic do_step(input logic a, input logic b, input logic exp_ud,
                           input logic [3:0] exp_pos, input string tag);
        dif.A = a; dif.B = b;
        cyc(5);
        chk({tag, ".early"}, dif.Step, 0);
        cyc(1);
        chk({tag, ".step"}, dif.Step, 1);
        chk({tag, ".ud"},   dif.UD, exp_ud);
        chk({tag, ".pos"},  dif.Position, exp_pos);
        cyc(1);
        chk({tag, ".pulse"}, dif.Step, 0);
        cyc(3);
    endtask

    initial begin
        rst = 1'b1; dif.A = 1'b0; dif.B = 1'b0; dif.ErrClr = 1'b0;
`ifdef QUAD_INDEX_EN
        dif.Z = 1'b0;
`endif
        // Reset with AB=11: no spurious step out of INIT
        s0 = step_cnt;
        do_reset(1'b1, 1'b1, "rst11");
        cyc(10);
        chk("init.nostep", step_cnt - s0, 0);
        chk("init.err", dif.Err, 0);
        chk("init.pos", dif.Position, 0);
        chk("init.ud",  dif.UD, 1);

        // Up sequence from 00
        do_reset(1'b0, 1'b0, "rst00a");
        do_step(0, 1, 1, 4'd1, "up1");
        do_step(1, 1, 1, 4'd2, "up2");
        do_step(1, 0, 1, 4'd3, "up3");
        do_step(0, 0, 1, 4'd4, "up4");

        // Down sequence from 0 wraps
        do_reset(1'b0, 1'b0, "rst00b");
        do_step(1, 0, 0, 4'd15, "dn1");
        do_step(1, 1, 0, 4'd14, "dn2");
        do_step(0, 1, 0, 4'd13, "dn3");
        do_step(0, 0, 0, 4'd12, "dn4");

        // Two-sample glitch is rejected
        s0 = step_cnt;
        dif.B = 1'b1; cyc(2); dif.B = 1'b0; cyc(12);
        chk("glitch2.steps", step_cnt - s0, 0);
        chk("glitch2.pos", dif.Position, 12);

        // Three-sample pulse is accepted, then its return is a down step
        s0 = step_cnt; u0 = up_cnt;
        dif.B = 1'b1; cyc(3); dif.B = 1'b0; cyc(14);
        chk("glitch3.steps", step_cnt - s0, 2);
        chk("glitch3.ups", up_cnt - u0, 1);
        chk("glitch3.pos", dif.Position, 12);

        // Illegal 00->11 jump
        s0 = step_cnt;
        dif.A = 1'b1; dif.B = 1'b1; cyc(10);
        chk("jump1.err", dif.Err, 1);
        chk("jump1.steps", step_cnt - s0, 0);
        chk("jump1.pos", dif.Position, 12);

        // Second jump 11->00 registers on the same edge ErrClr is sampled: set wins
        dif.A = 1'b0; dif.B = 1'b0;
        cyc(5);
        dif.ErrClr = 1'b1;
        cyc(1);
        dif.ErrClr = 1'b0;
        chk("jump2.setwins", dif.Err, 1);
        cyc(3);
        dif.ErrClr = 1'b1;
        cyc(1);
        dif.ErrClr = 1'b0;
        chk("errclr", dif.Err, 0);
        chk("jump2.steps", step_cnt - s0, 0);

        // Decoding resumes from the carried-over filtered state
        do_step(0, 1, 1, 4'd13, "resume");
        do_step(0, 0, 0, 4'd12, "resdn");

        // Mid-operation reset clears Err, UD and Position
        dif.A = 1'b1; dif.B = 1'b1; cyc(10);
        chk("jump3.err", dif.Err, 1);
        do_reset(1'b1, 1'b1, "rstmid");

`ifdef QUAD_INDEX_EN
        // Walk to Position 7, then index and an up step land together
        do_step(1, 0, 1, 4'd1, "ix1");
        do_step(0, 0, 1, 4'd2, "ix2");
        do_step(0, 1, 1, 4'd3, "ix3");
        do_step(1, 1, 1, 4'd4, "ix4");
        do_step(1, 0, 1, 4'd5, "ix5");
        do_step(0, 0, 1, 4'd6, "ix6");
        do_step(0, 1, 1, 4'd7, "ix7");
        dif.Z = 1'b1;
        fork
            begin
                repeat (5) @(posedge clk);
                #1 dif.Z = 1'b0;
            end
        join_none
        do_step(1, 1, 1, 4'd0, "index");
        do_step(1, 0, 1, 4'd1, "postix");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
